// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester encoder: FSM states, chip mapping, symbols.
// Benches import this package too, to build frames from the same symbol constants.
package manchester_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_GAP  = 2'd3
   } enc_state_e;

   localparam logic [7:0] IDLE_WORD_DEFAULT = 8'hAA;
   localparam logic [7:0] SYM_DATA_ESC      = 8'hD5;
   localparam logic [7:0] SYM_ESCAPE        = 8'hE5;

   // Data bit k lands in chips 2k (sent first) and 2k+1; polarity swaps the chip order.
   function automatic logic [7:0] encode_nibble(input logic [3:0] nib, input logic pol);
      logic [7:0] word;
      word = '0;
      for (int k = 0; k < 4; k++) begin
         word[2*k]   = nib[k] ^ pol;
         word[2*k+1] = ~(nib[k] ^ pol);
      end
      return word;
   endfunction

endpackage

// File: rtl/manchester_encoder.sv
// Byte-to-chip Manchester encoder: one byte in, two chip words out, with an inter-frame gap.
// Define MANCHESTER_IDLE_FILL_EN to transmit IDLE_WORD during idle and gap time.
module manchester_encoder
   import manchester_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IFG_WORDS  = 4,
   parameter bit          POLARITY   = 1'b0,
   parameter logic [7:0]  IDLE_WORD  = IDLE_WORD_DEFAULT
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   enc_state_e state_q, state_d;
   logic [7:0] byte_q, byte_d;
   logic       last_q, last_d;
   logic [7:0] gap_q, gap_d;
   logic [7:0] tdata_q, tdata_d;
   logic       tlast_q, tlast_d;

   logic       s_hs;
   logic       m_hs;
   logic       idle_take;
   logic       idle_open;
   logic [7:0] new_byte;

   assign s_hs     = s_axis_tvalid && s_axis_tready;
   assign m_hs     = m_axis_tvalid && m_axis_tready;
   assign new_byte = s_hs ? s_axis_tdata : byte_q;

`ifdef MANCHESTER_IDLE_FILL_EN
   // A byte accepted while an idle word is still stalled waits here until that word goes out.
   logic pend_q, pend_d;
   logic tvalid_q;

   assign idle_take     = (s_hs || pend_q) && (!m_axis_tvalid || m_axis_tready);
   assign idle_open     = !pend_q;
   assign m_axis_tvalid = tvalid_q;

   always_comb begin
      pend_d = pend_q;
      if (state_q == ST_IDLE) begin
         if (idle_take) begin
            pend_d = 1'b0;
         end else if (s_hs) begin
            pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pend_q   <= 1'b0;
         tvalid_q <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         tvalid_q <= 1'b1;
      end
   end
`else
   assign idle_take     = s_hs;
   assign idle_open     = 1'b1;
   assign m_axis_tvalid = (state_q == ST_LO) || (state_q == ST_HI);
`endif

   assign s_axis_tready = aresetn &&
                          (((state_q == ST_IDLE) && idle_open) ||
                           ((state_q == ST_HI) && m_axis_tready && !last_q));

   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      last_d  = last_q;
      gap_d   = gap_q;
      tdata_d = tdata_q;
      tlast_d = tlast_q;

      unique case (state_q)
         ST_IDLE: begin
            if (s_hs) begin
               byte_d = s_axis_tdata;
               last_d = s_axis_tlast;
            end
            if (idle_take) begin
               state_d = ST_LO;
               tdata_d = encode_nibble(new_byte[3:0], POLARITY);
               tlast_d = 1'b0;
            end
         end
         ST_LO: begin
            if (m_hs) begin
               state_d = ST_HI;
               tdata_d = encode_nibble(byte_q[7:4], POLARITY);
               tlast_d = last_q;
            end
         end
         ST_HI: begin
            if (m_hs) begin
               tlast_d = 1'b0;
               if (last_q) begin
                  state_d = ST_GAP;
                  gap_d   = 8'(IFG_WORDS);
                  tdata_d = IDLE_WORD;
               end else if (s_hs) begin
                  state_d = ST_LO;
                  byte_d  = s_axis_tdata;
                  last_d  = s_axis_tlast;
                  tdata_d = encode_nibble(s_axis_tdata[3:0], POLARITY);
               end else begin
                  state_d = ST_IDLE;
                  tdata_d = IDLE_WORD;
               end
            end
         end
         ST_GAP: begin
            // In fill mode tvalid is high here, so a ready cycle is exactly one idle-word handshake.
            if (m_axis_tready) begin
               gap_d = gap_q - 8'd1;
               if (gap_q <= 8'd1) begin
                  state_d = ST_IDLE;
                  gap_d   = 8'd0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
         byte_q  <= 8'd0;
         last_q  <= 1'b0;
         gap_q   <= 8'd0;
         tdata_q <= 8'd0;
         tlast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
         tdata_q <= tdata_d;
         tlast_q <= tlast_d;
      end
   end

   assign m_axis_tdata = tdata_q;
   assign m_axis_tlast = tlast_q;

endmodule
